// File: rtl/speed_step_scheduler_pkg.sv
// Shared types and default timing for the speed-step scheduler.
// Optional feature macro used by this block: STEP_CLICK_EN.
package speed_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_REPEAT  = 3'd2,
        ST_DERATE  = 3'd3,
        ST_LOCKOUT = 3'd4
    } sched_state_t;

    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_ACCEL  = 2'd1;
    localparam logic [1:0] SRC_DECEL  = 2'd2;
    localparam logic [1:0] SRC_DERATE = 2'd3;

    localparam int DEF_INITIAL_HOLD_CYCLES = 300;
    localparam int DEF_REPEAT_CYCLES       = 150;
    localparam int DEF_DERATE_CYCLES       = 100;
    localparam int DEF_CLICK_TICKS         = 20;

    // Wide enough for every tick threshold the scheduler loads.
    localparam int TMR_W = 16;

endpackage

// File: rtl/speed_step_scheduler_if.sv
// Scheduler-side bundle: tick, button levels and level inputs in; step commands,
// grant, lockout and click out. master = scheduler, slave = surrounding logic.
interface speed_step_scheduler_if #(
    parameter int LVL_W = 4
) ();
    logic             tick_1khz;
    logic             accel_lvl;
    logic             decel_lvl;
    logic [LVL_W-1:0] cur_level;
    logic [LVL_W-1:0] max_level;
    logic             step_up;
    logic             step_down;
    logic [1:0]       grant_src;
    logic             lockout;
    logic             click;

    modport master (
        input  tick_1khz, accel_lvl, decel_lvl, cur_level, max_level,
        output step_up, step_down, grant_src, lockout, click
    );

    modport slave (
        output tick_1khz, accel_lvl, decel_lvl, cur_level, max_level,
        input  step_up, step_down, grant_src, lockout, click
    );
endinterface

// File: rtl/speed_step_scheduler_hold_repeat_timer.sv
// Tick counter with an initial and a repeat threshold; fire is combinational on the
// tick that reaches the active threshold, after which the repeat threshold applies.
module hold_repeat_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] init_thr,
    input  logic [CNT_W-1:0] rep_thr,
    output logic             fire
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] thr;
    logic             repeating;

    always_comb begin
        cnt_inc = cnt + 1'b1;
        thr     = repeating ? rep_thr : init_thr;
        fire    = run && (cnt_inc == thr);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt       <= '0;
            repeating <= 1'b0;
        end else if (run) begin
            if (fire) begin
                cnt       <= '0;
                repeating <= 1'b1;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end
endmodule

// File: rtl/speed_step_scheduler.sv
// Arbitrates accel/decel buttons and gear derate into one-cycle step commands.
// Define STEP_CLICK_EN to drive the piezo click pulse; otherwise click is tied low.
module speed_step_scheduler
    import speed_sched_pkg::*;
#(
    parameter int INITIAL_HOLD_CYCLES = DEF_INITIAL_HOLD_CYCLES,
    parameter int REPEAT_CYCLES       = DEF_REPEAT_CYCLES,
    parameter int DERATE_CYCLES       = DEF_DERATE_CYCLES,
    parameter int LVL_W               = 4
) (
    input  logic                   clk_50mhz,
    input  logic                   rst,
    speed_step_scheduler_if.master sb,
    output sched_state_t           state_dbg
);
    localparam logic [TMR_W-1:0] HOLD_INIT_THR   = TMR_W'(INITIAL_HOLD_CYCLES + 1);
    localparam logic [TMR_W-1:0] HOLD_REP_THR    = TMR_W'(REPEAT_CYCLES);
    localparam logic [TMR_W-1:0] DERATE_INIT_THR = TMR_W'(1);
    localparam logic [TMR_W-1:0] DERATE_REP_THR  = TMR_W'(DERATE_CYCLES);

    sched_state_t     state;
    logic [LVL_W-1:0] cur_lvl, max_lvl;
    logic             accel_q, decel_q, edge_arm;
    logic             step_up_q, step_down_q, lockout_q;
    logic [1:0]       grant_q;
    logic             accel_rise, decel_rise, other_rise, granted_lvl;
    logic             up_ok, dn_ok, over_max, in_hold;
    logic             tmr_clear, tmr_run, tmr_fire;
    logic [TMR_W-1:0] tmr_init_thr, tmr_rep_thr;

    assign cur_lvl = sb.cur_level;
    assign max_lvl = sb.max_level;

    // edge_arm masks the first cycle after reset so a button held through reset
    // has to be released and pressed again.
    always_comb begin
        accel_rise   = edge_arm && sb.accel_lvl && !accel_q;
        decel_rise   = edge_arm && sb.decel_lvl && !decel_q;
        up_ok        = cur_lvl < max_lvl;
        dn_ok        = cur_lvl != '0;
        over_max     = cur_lvl > max_lvl;
        granted_lvl  = (grant_q == SRC_ACCEL) ? sb.accel_lvl : sb.decel_lvl;
        other_rise   = (grant_q == SRC_ACCEL) ? decel_rise : accel_rise;
        in_hold      = (state == ST_HOLD) || (state == ST_REPEAT);
        tmr_clear    = (state == ST_IDLE) || (state == ST_LOCKOUT) ||
                       ((state == ST_DERATE) && decel_rise);
        tmr_run      = sb.tick_1khz &&
                       ((in_hold && granted_lvl && !other_rise) ||
                        ((state == ST_DERATE) && !decel_rise && over_max));
        tmr_init_thr = (state == ST_DERATE) ? DERATE_INIT_THR : HOLD_INIT_THR;
        tmr_rep_thr  = (state == ST_DERATE) ? DERATE_REP_THR  : HOLD_REP_THR;
    end

    hold_repeat_timer #(.CNT_W(TMR_W)) u_timer (
        .clk      (clk_50mhz),
        .rst      (rst),
        .clear    (tmr_clear),
        .run      (tmr_run),
        .init_thr (tmr_init_thr),
        .rep_thr  (tmr_rep_thr),
        .fire     (tmr_fire)
    );

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state       <= ST_IDLE;
            accel_q     <= 1'b0;
            decel_q     <= 1'b0;
            edge_arm    <= 1'b0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            lockout_q   <= 1'b0;
            grant_q     <= SRC_NONE;
        end else begin
            accel_q     <= sb.accel_lvl;
            decel_q     <= sb.decel_lvl;
            edge_arm    <= 1'b1;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accel_rise && decel_rise) begin
                        state     <= ST_LOCKOUT;
                        lockout_q <= 1'b1;
                    end else if (accel_rise) begin
                        step_up_q <= up_ok;
                        state     <= ST_HOLD;
                        grant_q   <= SRC_ACCEL;
                    end else if (decel_rise) begin
                        step_down_q <= dn_ok;
                        state       <= ST_HOLD;
                        grant_q     <= SRC_DECEL;
                    end else if (over_max) begin
                        state   <= ST_DERATE;
                        grant_q <= SRC_DERATE;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (other_rise) begin
                        state     <= ST_LOCKOUT;
                        lockout_q <= 1'b1;
                        grant_q   <= SRC_NONE;
                    end else if (!granted_lvl) begin
                        state   <= ST_IDLE;
                        grant_q <= SRC_NONE;
                    end else if (tmr_fire) begin
                        state       <= ST_REPEAT;
                        step_up_q   <= (grant_q == SRC_ACCEL) && up_ok;
                        step_down_q <= (grant_q == SRC_DECEL) && dn_ok;
                    end
                end
                ST_DERATE: begin
                    if (decel_rise) begin
                        step_down_q <= dn_ok;
                        state       <= ST_HOLD;
                        grant_q     <= SRC_DECEL;
                    end else if (!over_max) begin
                        state   <= ST_IDLE;
                        grant_q <= SRC_NONE;
                    end else if (tmr_fire) begin
                        step_down_q <= dn_ok;
                    end
                end
                ST_LOCKOUT: begin
                    if (!sb.accel_lvl && !sb.decel_lvl) begin
                        state     <= ST_IDLE;
                        lockout_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    lockout_q <= 1'b0;
                    grant_q   <= SRC_NONE;
                end
            endcase
        end
    end

    assign sb.step_up   = step_up_q;
    assign sb.step_down = step_down_q;
    assign sb.grant_src = grant_q;
    assign sb.lockout   = lockout_q;
    assign state_dbg    = state;

`ifdef STEP_CLICK_EN
    localparam int CLICK_W = 8;
    logic [CLICK_W-1:0] click_cnt;

    // Loaded on the step pulse itself; the pulse term covers that first cycle.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            click_cnt <= '0;
        end else if (step_up_q || step_down_q) begin
            click_cnt <= CLICK_W'(DEF_CLICK_TICKS);
        end else if (sb.tick_1khz && (click_cnt != '0)) begin
            click_cnt <= click_cnt - 1'b1;
        end
    end

    assign sb.click = step_up_q || step_down_q || (click_cnt != '0);
`else
    assign sb.click = 1'b0;
`endif

endmodule

// File: tb/tb_speed_step_scheduler.sv
// Scoreboard bench for speed_step_scheduler: scenarios push expected steps
// (direction, tick stamp) into a queue; a negedge monitor pops and compares.
module tb_speed_step_scheduler;
  import speed_sched_pkg::*;

  localparam int LVL_W = 4;
  localparam int TICK_PER = 4;
  localparam int INIT = 300;
  localparam int REP = 150;
  localparam int DER = 100;
  localparam int CLICK = 20;
  localparam int EW = 25;

  // clock / reset
  logic clk_50mhz = 1'b0;
  logic rst;
  always #10 clk_50mhz = ~clk_50mhz;

  speed_step_scheduler_if #(.LVL_W(LVL_W)) sb ();
  sched_state_t state_dbg;

  speed_step_scheduler #(
    .INITIAL_HOLD_CYCLES(INIT),
    .REPEAT_CYCLES(REP),
    .DERATE_CYCLES(DER),
    .LVL_W(LVL_W)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .rst(rst),
    .sb(sb),
    .state_dbg(state_dbg)
  );

  // speed-level register fed by the step commands
  logic [LVL_W-1:0] level;
  logic load_en;
  logic [LVL_W-1:0] load_val;
  always @(posedge clk_50mhz) begin
    if (load_en) level <= load_val;
    else if (sb.step_up) level <= level + 1'b1;
    else if (sb.step_down) level <= level - 1'b1;
  end
  assign sb.cur_level = level;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int tick_count = 0;
  int phase = 0;
  int model_level = 0;
  int mx = 9;
  int last_step = 0;
  bit step_seen = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // monitor
  logic [EW-1:0] act_e, exp_e;
  always @(negedge clk_50mhz) begin
    if (rst) step_seen = 0;
    if (sb.step_up || sb.step_down) begin
      checks++;
      act_e = {sb.step_up, 24'(tick_count)};
      if (sb.step_up && sb.step_down) begin
        failures++;
        $display("FAIL both_steps: step_up and step_down high at tick %0d", tick_count);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_step: got up=%0d at tick %0d, want no step", act_e[24], act_e[23:0]);
      end else begin
        exp_e = exp_q.pop_front();
        if (act_e != exp_e) begin
          failures++;
          $display("FAIL step: got up=%0d tick=%0d, want up=%0d tick=%0d",
                   act_e[24], act_e[23:0], exp_e[24], exp_e[23:0]);
        end
      end
      last_step = tick_count;
      step_seen = 1;
    end
    if (!sb.tick_1khz) begin
`ifdef STEP_CLICK_EN
      check("click", int'(sb.click), int'(step_seen && (tick_count - last_step) < CLICK));
`else
      check("click", int'(sb.click), 0);
`endif
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk_50mhz);
    #1;
    phase = (phase + 1) % TICK_PER;
    sb.tick_1khz = (phase == 0);
    if (phase == 0) tick_count++;
  endtask

  task automatic goto_phase(int p);
    cyc();
    while (phase != p) cyc();
  endtask

  task automatic set_levels(int lvl, int m);
    sb.max_level = 4'd15;
    cyc();
    load_en = 1'b1;
    load_val = 4'(lvl);
    cyc();
    load_en = 1'b0;
    sb.max_level = 4'(m);
    mx = m;
    model_level = lvl;
    cyc();
    cyc();
  endtask

  // expected steps for a press held h ticks, with saturation applied
  task automatic push_steps(bit up, int h, int t0);
    int n;
    int k;
    n = (h > INIT) ? 1 + (h - INIT + REP - 1) / REP : 1;
    for (int i = 0; i < n; i++) begin
      k = (i == 0) ? 0 : INIT + 1 + (i - 1) * REP;
      if (up && model_level < mx) begin
        exp_q.push_back({1'b1, 24'(t0 + k)});
        model_level++;
      end else if (!up && model_level > 0) begin
        exp_q.push_back({1'b0, 24'(t0 + k)});
        model_level--;
      end
    end
  endtask

  task automatic hold_button(bit up, int h, bit coincide);
    int t0;
    goto_phase(2);
    t0 = tick_count;
    push_steps(up, h, t0);
    if (up) sb.accel_lvl = 1'b1;
    else sb.decel_lvl = 1'b1;
    cyc();
    check("grant_press", int'(sb.grant_src), up ? 1 : 2);
    while (tick_count < t0 + h) cyc();
    if (coincide) goto_phase(0);
    else cyc();
    sb.accel_lvl = 1'b0;
    sb.decel_lvl = 1'b0;
    cyc();
    cyc();
    check("state_after_release", int'(state_dbg), int'(ST_IDLE));
    check("pending_steps", exp_q.size(), 0);
    check("level", int'(level), model_level);
  endtask

  task automatic lockout_case();
    int t0;
    goto_phase(2);
    t0 = tick_count;
    push_steps(1'b1, 0, t0);
    sb.accel_lvl = 1'b1;
    while (tick_count < t0 + 100) cyc();
    cyc();
    sb.decel_lvl = 1'b1;
    cyc();
    cyc();
    check("lockout_on", int'(sb.lockout), 1);
    while (tick_count < t0 + 500) cyc();
    sb.accel_lvl = 1'b0;
    repeat (10) cyc();
    check("lockout_decel_held", int'(sb.lockout), 1);
    sb.decel_lvl = 1'b0;
    cyc();
    cyc();
    check("lockout_off", int'(sb.lockout), 0);
    check("state_after_lockout", int'(state_dbg), int'(ST_IDLE));
    check("level_after_lockout", int'(level), model_level);
  endtask

  task automatic derate_case(int from_lvl, int to_max);
    int t0;
    int guard;
    set_levels(from_lvl, 9);
    goto_phase(2);
    sb.max_level = 4'(to_max);
    mx = to_max;
    t0 = tick_count;
    for (int i = 0; i < from_lvl - to_max; i++)
      exp_q.push_back({1'b0, 24'(t0 + 1 + i * DER)});
    model_level = to_max;
    cyc();
    check("grant_derate", int'(sb.grant_src), 3);
    guard = 0;
    while (state_dbg != ST_IDLE && guard < 4000) begin
      cyc();
      guard++;
    end
    check("derate_timeout", int'(guard < 4000), 1);
    cyc();
    check("derate_level", int'(level), model_level);
    check("derate_pending", exp_q.size(), 0);
  endtask

  task automatic reset_case();
    int t0;
    set_levels(2, 9);
    goto_phase(2);
    t0 = tick_count;
    push_steps(1'b1, 0, t0);
    sb.accel_lvl = 1'b1;
    while (tick_count < t0 + 50) cyc();
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_state", int'(state_dbg), int'(ST_IDLE));
    check("rst_grant", int'(sb.grant_src), 0);
    check("rst_step_up", int'(sb.step_up), 0);
    rst = 1'b0;
    t0 = tick_count;
    while (tick_count < t0 + 400) cyc();
    sb.accel_lvl = 1'b0;
    cyc();
    cyc();
    check("rst_level", int'(level), model_level);
    check("rst_pending", exp_q.size(), 0);
  endtask

  initial begin
    int lvl, m, h;
    bit up, co;
    rst = 1'b1;
    sb.tick_1khz = 1'b0;
    sb.accel_lvl = 1'b0;
    sb.decel_lvl = 1'b0;
    sb.max_level = 4'd9;
    load_en = 1'b1;
    load_val = '0;
    repeat (4) cyc();
    check("reset_step_up", int'(sb.step_up), 0);
    check("reset_step_down", int'(sb.step_down), 0);
    check("reset_grant", int'(sb.grant_src), 0);
    check("reset_lockout", int'(sb.lockout), 0);
    check("reset_click", int'(sb.click), 0);
    check("reset_state", int'(state_dbg), int'(ST_IDLE));
    load_en = 1'b0;
    rst = 1'b0;
    cyc();

    set_levels(0, 9);
    hold_button(1'b1, 50, 1'b0);
    hold_button(1'b1, 700, 1'b0);
    hold_button(1'b0, 500, 1'b0);
    hold_button(1'b1, 320, 1'b0);
    lockout_case();
    derate_case(8, 3);
    set_levels(9, 9);
    hold_button(1'b1, 700, 1'b0);
    set_levels(0, 9);
    hold_button(1'b1, 700, 1'b0);
    set_levels(0, 15);
    hold_button(1'b1, 450, 1'b1);
    hold_button(1'b1, 451, 1'b0);
    hold_button(1'b0, 300, 1'b0);
    hold_button(1'b0, 301, 1'b0);
    set_levels(0, 9);
    hold_button(1'b0, 320, 1'b0);
    reset_case();

    for (int i = 0; i < 10; i++) begin
      lvl = $urandom_range(0, 9);
      m = $urandom_range(lvl, 12);
      up = 1'($urandom_range(0, 1));
      h = $urandom_range(0, 650);
      co = 1'($urandom_range(0, 1));
      set_levels(lvl, m);
      hold_button(up, h, co);
    end

    repeat (8) cyc();
    check("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
